// File: rtl/gpr_file.sv
// Architectural GPR file with HI/LO registers.
// Writes land on the clock edge; reads see a same-cycle write through a bypass.
module gpr_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_en,
  input  logic [ADDR_W-1:0] reg_write_dest,
  input  logic [DATA_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [1:0]        hilo_write_en,
  input  logic [DATA_W-1:0] hi_write_data,
  input  logic [DATA_W-1:0] lo_write_data,
  output logic [DATA_W-1:0] hi_data,
  output logic [DATA_W-1:0] lo_data
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] gpr_q [1:NREG-1];
  logic [DATA_W-1:0] gpr_d [1:NREG-1];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] rs_mem, rt_mem;

  always_comb begin
    gpr_d = gpr_q;
    for (int i = 1; i < NREG; i++) begin
      if (reg_write_en && reg_write_dest == ADDR_W'(i))
        gpr_d[i] = reg_write_data;
    end
    hi_d = hilo_write_en[1] ? hi_write_data : hi_q;
    lo_d = hilo_write_en[0] ? lo_write_data : lo_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++)
        gpr_q[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Stored lookups; index 0 has no storage and falls through as zero.
  always_comb begin
    rs_mem = '0;
    rt_mem = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs_addr == ADDR_W'(i))
        rs_mem = gpr_q[i];
      if (rt_addr == ADDR_W'(i))
        rt_mem = gpr_q[i];
    end
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    hi_data = '0;
    lo_data = '0;
    if (rst) begin
      if (rs_addr == '0)
        rs_data = '0;
      else if (reg_write_en && reg_write_dest == rs_addr)
        rs_data = reg_write_data;
      else
        rs_data = rs_mem;

      if (rt_addr == '0)
        rt_data = '0;
      else if (reg_write_en && reg_write_dest == rt_addr)
        rt_data = reg_write_data;
      else
        rt_data = rt_mem;

      hi_data = hi_d;
      lo_data = lo_d;
    end
  end

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: reset, write/read, bypass, r0,
// HI/LO, simultaneous writes and asynchronous reset.
module tb_gpr_file;

  logic        clk;
  logic        rst;
  logic        reg_write_en;
  logic [4:0]  reg_write_dest;
  logic [31:0] reg_write_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [1:0]  hilo_write_en;
  logic [31:0] hi_write_data;
  logic [31:0] lo_write_data;
  logic [31:0] hi_data;
  logic [31:0] lo_data;

  int checks = 0;
  int errors = 0;

  gpr_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .hilo_write_en  (hilo_write_en),
    .hi_write_data  (hi_write_data),
    .lo_write_data  (lo_write_data),
    .hi_data        (hi_data),
    .lo_data        (lo_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write_en   = 1'b0;
    reg_write_dest = 5'd0;
    reg_write_data = 32'h0;
    hilo_write_en  = 2'b00;
    hi_write_data  = 32'h0;
    lo_write_data  = 32'h0;
  endtask

  task automatic test_reset();
    rst            = 1'b0;
    rs_addr        = 5'd5;
    rt_addr        = 5'd5;
    reg_write_en   = 1'b1;
    reg_write_dest = 5'd5;
    reg_write_data = 32'hDEADBEEF;
    hilo_write_en  = 2'b11;
    hi_write_data  = 32'hCAFE0001;
    lo_write_data  = 32'hCAFE0002;
    #1;
    checks++;
    if (rs_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bypass_rs got %h exp %h", rs_data, 32'h0);
    end
    checks++;
    if (hi_data !== 32'h0 || lo_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bypass_hilo got %h/%h exp 0/0", hi_data, lo_data);
    end
    tick();
    tick();
    idle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rs_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_r5 got %h exp %h", rs_data, 32'h0);
    end
    checks++;
    if (hi_data !== 32'h0 || lo_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo got %h/%h exp 0/0", hi_data, lo_data);
    end
  endtask

  task automatic test_write_read();
    tick();
    reg_write_en   = 1'b1;
    reg_write_dest = 5'd3;
    reg_write_data = 32'h12345678;
    tick();
    reg_write_dest = 5'd6;
    reg_write_data = 32'h00000011;
    tick();
    idle();
    rs_addr = 5'd3;
    rt_addr = 5'd3;
    #1;
    checks++;
    if (rs_data !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_rs_r3 got %h exp %h", rs_data, 32'h12345678);
    end
    checks++;
    if (rt_data !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_rt_r3 got %h exp %h", rt_data, 32'h12345678);
    end
    rt_addr = 5'd6;
    #1;
    checks++;
    if (rt_data !== 32'h00000011) begin
      errors++;
      $display("FAIL wr_rt_r6 got %h exp %h", rt_data, 32'h00000011);
    end
  endtask

  task automatic test_bypass();
    tick();
    reg_write_en   = 1'b1;
    reg_write_dest = 5'd7;
    reg_write_data = 32'hA5A5A5A5;
    rs_addr        = 5'd7;
    rt_addr        = 5'd6;
    #1;
    checks++;
    if (rs_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_rs got %h exp %h", rs_data, 32'hA5A5A5A5);
    end
    checks++;
    if (rt_data !== 32'h00000011) begin
      errors++;
      $display("FAIL bypass_rt_r6 got %h exp %h", rt_data, 32'h00000011);
    end
    tick();
    reg_write_dest = 5'd9;
    reg_write_data = 32'h0BADF00D;
    rs_addr        = 5'd9;
    rt_addr        = 5'd9;
    #1;
    checks++;
    if (rs_data !== 32'h0BADF00D || rt_data !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL bypass_both got %h/%h exp %h", rs_data, rt_data,
               32'h0BADF00D);
    end
    tick();
    idle();
    rs_addr = 5'd7;
    #1;
    checks++;
    if (rs_data !== 32'hA5A5A5A5 || rt_data !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL bypass_stored got %h/%h exp %h/%h", rs_data, rt_data,
               32'hA5A5A5A5, 32'h0BADF00D);
    end
  endtask

  task automatic test_r0();
    tick();
    reg_write_en   = 1'b1;
    reg_write_dest = 5'd0;
    reg_write_data = 32'hFFFFFFFF;
    rs_addr        = 5'd0;
    rt_addr        = 5'd0;
    #1;
    checks++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      errors++;
      $display("FAIL r0_same got %h/%h exp 0/0", rs_data, rt_data);
    end
    tick();
    #1;
    checks++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      errors++;
      $display("FAIL r0_next got %h/%h exp 0/0", rs_data, rt_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rs_data !== 32'h0) begin
      errors++;
      $display("FAIL r0_after got %h exp %h", rs_data, 32'h0);
    end
  endtask

  task automatic test_hilo();
    tick();
    hilo_write_en = 2'b10;
    hi_write_data = 32'h1;
    lo_write_data = 32'h2;
    #1;
    checks++;
    if (hi_data !== 32'h1 || lo_data !== 32'h0) begin
      errors++;
      $display("FAIL hilo_10 got %h/%h exp 1/0", hi_data, lo_data);
    end
    tick();
    hilo_write_en = 2'b11;
    hi_write_data = 32'h3;
    lo_write_data = 32'h4;
    #1;
    checks++;
    if (hi_data !== 32'h3 || lo_data !== 32'h4) begin
      errors++;
      $display("FAIL hilo_11 got %h/%h exp 3/4", hi_data, lo_data);
    end
    tick();
    hilo_write_en = 2'b00;
    hi_write_data = 32'hEEEEEEEE;
    lo_write_data = 32'hDDDDDDDD;
    #1;
    checks++;
    if (hi_data !== 32'h3 || lo_data !== 32'h4) begin
      errors++;
      $display("FAIL hilo_hold got %h/%h exp 3/4", hi_data, lo_data);
    end
    tick();
    #1;
    checks++;
    if (hi_data !== 32'h3 || lo_data !== 32'h4) begin
      errors++;
      $display("FAIL hilo_hold2 got %h/%h exp 3/4", hi_data, lo_data);
    end
    idle();
  endtask

  task automatic test_no_write_leak();
    tick();
    reg_write_en   = 1'b0;
    reg_write_dest = 5'd3;
    reg_write_data = 32'h77777777;
    rs_addr        = 5'd3;
    rt_addr        = 5'd7;
    #1;
    checks++;
    if (rs_data !== 32'h12345678) begin
      errors++;
      $display("FAIL noleak_rs got %h exp %h", rs_data, 32'h12345678);
    end
    tick();
    #1;
    checks++;
    if (rs_data !== 32'h12345678 || rt_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL noleak_edge got %h/%h exp %h/%h", rs_data, rt_data,
               32'h12345678, 32'hA5A5A5A5);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    tick();
    reg_write_en   = 1'b1;
    reg_write_dest = 5'd10;
    reg_write_data = 32'hAAAA0000;
    hilo_write_en  = 2'b01;
    lo_write_data  = 32'h55;
    hi_write_data  = 32'h99;
    tick();
    reg_write_dest = 5'd31;
    reg_write_data = 32'h0000FFFF;
    hilo_write_en  = 2'b00;
    tick();
    idle();
    rs_addr = 5'd10;
    rt_addr = 5'd31;
    #1;
    checks++;
    if (rs_data !== 32'hAAAA0000 || rt_data !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL b2b_gpr got %h/%h exp %h/%h", rs_data, rt_data,
               32'hAAAA0000, 32'h0000FFFF);
    end
    checks++;
    if (hi_data !== 32'h3 || lo_data !== 32'h55) begin
      errors++;
      $display("FAIL b2b_hilo got %h/%h exp 3/55", hi_data, lo_data);
    end
  endtask

  task automatic test_async_reset();
    tick();
    rs_addr = 5'd3;
    rt_addr = 5'd10;
    #1;
    checks++;
    if (rs_data !== 32'h12345678 || hi_data !== 32'h3) begin
      errors++;
      $display("FAIL arst_pre got %h/%h exp %h/3", rs_data, hi_data,
               32'h12345678);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0 || hi_data !== 32'h0) begin
      errors++;
      $display("FAIL arst_low got %h/%h/%h exp 0/0/0", rs_data, rt_data,
               hi_data);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      errors++;
      $display("FAIL arst_rel_gpr got %h/%h exp 0/0", rs_data, rt_data);
    end
    checks++;
    if (hi_data !== 32'h0 || lo_data !== 32'h0) begin
      errors++;
      $display("FAIL arst_rel_hilo got %h/%h exp 0/0", hi_data, lo_data);
    end
    tick();
    #1;
    checks++;
    if (rs_data !== 32'h0 || hi_data !== 32'h0) begin
      errors++;
      $display("FAIL arst_after got %h/%h exp 0/0", rs_data, hi_data);
    end
  endtask

  initial begin
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_hilo();
    test_no_write_leak();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_file.md
Name: gpr_file

Overview:
- Architectural register file sitting at the receiving end of the writeback stage's register-write interface.
- Accepts one GPR write per cycle (enable/destination/data) and serves the decode stage through two combinational read ports.
- Also holds the HI/LO multiply/divide result registers.
- Write-through bypass: a value written in cycle N is visible on the read ports in cycle N, so no separate WB→ID forwarding is needed.

Parameters:
- DATA_W, 32, width of every GPR and of HI/LO.
- ADDR_W, 5, GPR index width; register count is 2**ADDR_W, index 0 hardwired to zero.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; low = in reset.
- reg_write_en  input  1  GPR write request from writeback.
- reg_write_dest  input  ADDR_W  GPR write index.
- reg_write_data  input  DATA_W  GPR write data.
- rs_addr  input  ADDR_W  read port A index.
- rt_addr  input  ADDR_W  read port B index.
- rs_data  output  DATA_W  read port A data, combinational.
- rt_data  output  DATA_W  read port B data, combinational.
- hilo_write_en  input  2  bit1 = write HI, bit0 = write LO.
- hi_write_data  input  DATA_W  HI write data.
- lo_write_data  input  DATA_W  LO write data.
- hi_data  output  DATA_W  current HI, bypassed.
- lo_data  output  DATA_W  current LO, bypassed.

Behaviour:
- Storage: registers 1..2**ADDR_W-1 plus HI and LO are flops; register 0 has no storage.
- Reset:
  - rst low asynchronously clears every GPR, HI and LO to 0.
  - While rst is low, rs_data, rt_data, hi_data and lo_data are forced to 0 and all writes are ignored.
  - Reset deasserted mid-stream: the first rising edge with rst high is a normal write edge.
- GPR write: on a rising edge with rst high, reg_write_en=1 and reg_write_dest≠0, register[dest] ← reg_write_data. Writes to index 0 are silently dropped. Latency is 1 edge to storage.
- GPR read, per port independently:
  - addr = 0 → 0.
  - Else reg_write_en=1 and reg_write_dest=addr → reg_write_data (same-cycle bypass).
  - Else → stored register[addr].
- Both ports may read the same index, including the write index; both return the identical value.
- HI/LO write: on a rising edge with rst high, hilo_write_en[1] → HI ← hi_write_data and hilo_write_en[0] → LO ← lo_write_data. The two bits are independent; both may be set in one cycle.
- HI/LO read: hi_data = hilo_write_en[1] ? hi_write_data : HI. lo_data is analogous with bit0.
- Simultaneous GPR write and HI/LO write in one cycle: both take effect, with no interaction.
- No X propagation: when write enables are 0, outputs must not depend on the write data or dest inputs.
- Purely combinational read paths, no stall/handshake; the write interface is fire-and-forget, and the block is always ready.

Test Plan:
- Reset: hold rst=0 with reg_write_en=1, dest=5, data=0xDEADBEEF; release rst. → rs_addr=5 reads 0. HI=LO=0.
- Write then read: write r3=0x12345678. Next cycle rs_addr=3, rt_addr=3 → both 0x12345678.
- Bypass: same cycle write r7=0xA5A5A5A5 with rs_addr=7 → rs_data=0xA5A5A5A5 before the edge. rt_addr=6 (stored 0x11) → 0x11.
- r0: write dest=0 data=0xFFFFFFFF with rs_addr=0 in the same cycle and the next → rs_data=0 both cycles.
- HI/LO: hilo_write_en=2'b10, hi=0x1, lo=0x2 → hi_data=0x1 same cycle, lo_data=0 (previous). Next cycle en=2'b11, hi=0x3, lo=0x4 → 0x3/0x4, then held after en=0.
- Async reset mid-operation: with r3=0x12345678 and HI=0x3, pulse rst low between clock edges → rs_data (r3) and hi_data drop to 0 immediately, and stay 0 after release.
